sequential_divider_const_time: RTL

//  Constant-time sequential unsigned divider: the inverse operation to the constant-time

---
 rtl/sequential_divider_const_time.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sequential_divider_const_time.sv
// ----------------------------------------------------------------------------
// sequential_divider_const_time
//
// Constant-time unsigned restoring divider. One quotient bit is produced per
// clock, and every operation takes exactly WIDTH cycles from the accepting
// edge to quotientDone, whatever the operands are (divide-by-zero included).
// It uses the same start/done handshake as the constant-time shift-add
// multiplier that sits beside it in the arithmetic unit.
//
// Handshake: start is sampled only in IDLE or DONE. A high start on a rising
// edge in either state accepts the operands on that edge. busy is high
// throughout the WIDTH calculation cycles. quotientDone goes high after the
// last step and stays high until the next accepted start. quotient,
// remainder and divByZero are valid while quotientDone is high. Any start
// seen during CALC is ignored.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset, aborts any op
//   start        in   1      operation request
//   dividend     in   WIDTH  unsigned dividend, captured on the accept edge
//   divisor      in   WIDTH  unsigned divisor, captured on the accept edge
//   quotient     out  WIDTH  registered quotient
//   remainder    out  WIDTH  registered remainder
//   quotientDone out  1      result valid (DONE state)
//   busy         out  1      calculation in progress (CALC state)
//   divByZero    out  1      captured divisor was zero (with quotientDone)
//   o_dbg_state  out  2      current FSM state, for observation only
// ----------------------------------------------------------------------------
module sequential_divider_const_time #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             quotientDone,
    output logic             busy,
    output logic             divByZero,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_dq;         // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_dv;         // captured divisor
    logic [WIDTH-1:0] r_pr;         // partial remainder
    logic [CW-1:0]    r_count;      // index of the step being performed
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_done;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last_step;
    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_d;
    logic             w_ge;
    logic [WIDTH-1:0] w_pr_next;
    logic [WIDTH-1:0] w_dq_next;

    // ------------------------------------------------------------------
    // Restoring step. The subtraction is always evaluated so the step
    // costs the same regardless of the data.
    //
    // The partial remainder is conceptually WIDTH+1 bits wide, but after
    // any step its top bit is zero: a kept difference is below the
    // divisor, and a restored shift value is only kept when it is below
    // the divisor too. Only WIDTH bits are therefore stored; the extra
    // bit exists only inside the shift/subtract below.
    // ------------------------------------------------------------------
    always_comb begin
        w_s       = {r_pr, r_dq[WIDTH-1]};
        w_d       = w_s - {1'b0, r_dv};
        w_ge      = ~w_d[WIDTH];
        w_pr_next = w_ge ? w_d[WIDTH-1:0] : w_s[WIDTH-1:0];
        w_dq_next = {r_dq[WIDTH-2:0], w_ge};
    end

    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last_step = (r_state == ST_CALC) && (r_count == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_count == CW'(WIDTH - 1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_next = ST_CALC;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath working registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dq    <= '0;
            r_dv    <= '0;
            r_pr    <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_dq    <= dividend;
            r_dv    <= divisor;
            r_pr    <= '0;
            r_count <= '0;
        end else if (r_state == ST_CALC) begin
            r_dq    <= w_dq_next;
            r_pr    <= w_pr_next;
            r_count <= r_count + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result registers: written only on the final step, so the previous
    // result stays visible throughout a new calculation. Done and the
    // divide-by-zero flag drop on the accepting edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else if (w_last_step) begin
            r_quotient  <= w_dq_next;
            r_remainder <= w_pr_next;
            r_done      <= 1'b1;
            r_dbz       <= (r_dv == '0);
        end
    end

    assign quotient     = r_quotient;
    assign remainder    = r_remainder;
    assign quotientDone = r_done;
    assign divByZero    = r_dbz;
    assign busy         = (r_state == ST_CALC);
    assign o_dbg_state  = r_state;

endmodule
